// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer controller: front bank feeds the display, back bank takes renderer writes.
// Optional post-swap clear of the new back bank is compiled in with FB_SWAP_CLEAR_EN.
`timescale 1ns/1ps
module fb_swap_ctrl #(
   parameter int ADDR_W = 10,
   parameter int PIX_W  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [PIX_W-1:0]     rd_data_top,
   output logic [PIX_W-1:0]     rd_data_btm,
   input  logic                 frame_end,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [2*PIX_W-1:0]   wr_data,
   input  logic                 swap_req,
   output logic                 swap_done,
   input  logic [PIX_W-1:0]     clear_color,
   output logic                 clr_busy,
   output logic                 front_sel,
   output logic [ADDR_W-1:0]    bank_a_addr,
   output logic                 bank_a_we,
   output logic [2*PIX_W-1:0]   bank_a_wdata,
   input  logic [2*PIX_W-1:0]   bank_a_rdata,
   output logic [ADDR_W-1:0]    bank_b_addr,
   output logic                 bank_b_we,
   output logic [2*PIX_W-1:0]   bank_b_wdata,
   input  logic [2*PIX_W-1:0]   bank_b_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      SWAP_PEND
`ifdef FB_SWAP_CLEAR_EN
      , CLEAR
`endif
   } state_t;

   state_t               state;
   state_t               next_state;
   logic                 swap_fire;
   logic                 front_sel_d;
   logic                 back_we;
   logic [ADDR_W-1:0]    back_addr;
   logic [2*PIX_W-1:0]   back_wdata;

`ifdef FB_SWAP_CLEAR_EN
   logic [ADDR_W-1:0]    clr_cnt;
`endif

   always_comb begin
      next_state = state;
      swap_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (swap_req) next_state = SWAP_PEND;
         end
         SWAP_PEND: begin
            if (frame_end) begin
               swap_fire  = 1'b1;
`ifdef FB_SWAP_CLEAR_EN
               next_state = CLEAR;
`else
               next_state = IDLE;
`endif
            end
         end
`ifdef FB_SWAP_CLEAR_EN
         CLEAR: begin
            if (clr_cnt == '1) next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // wr_ready is registered so it stays low through reset and rises on the first edge after release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         front_sel   <= 1'b0;
         front_sel_d <= 1'b0;
         swap_done   <= 1'b0;
         wr_ready    <= 1'b0;
      end else begin
         front_sel_d <= front_sel;
         swap_done   <= swap_fire;
         wr_ready    <= (next_state == IDLE);
         if (swap_fire) front_sel <= ~front_sel;
      end
   end

`ifdef FB_SWAP_CLEAR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_cnt  <= '0;
         clr_busy <= 1'b0;
      end else begin
         clr_busy <= (next_state == CLEAR);
         if (clr_busy) clr_cnt <= clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
         else          clr_cnt <= '0;
      end
   end

   always_comb begin
      back_we    = clr_busy | (wr_valid & wr_ready);
      back_addr  = clr_busy ? clr_cnt : wr_addr;
      back_wdata = clr_busy ? {clear_color, clear_color} : wr_data;
   end
`else
   logic unused_clear;
   assign unused_clear = ^clear_color;
   assign clr_busy     = 1'b0;

   always_comb begin
      back_we    = wr_valid & wr_ready;
      back_addr  = wr_addr;
      back_wdata = wr_data;
   end
`endif

   always_comb begin
      bank_a_addr  = rd_addr;
      bank_a_we    = 1'b0;
      bank_a_wdata = '0;
      bank_b_addr  = rd_addr;
      bank_b_we    = 1'b0;
      bank_b_wdata = '0;
      if (front_sel) begin
         bank_a_addr  = back_addr;
         bank_a_we    = back_we;
         bank_a_wdata = back_wdata;
      end else begin
         bank_b_addr  = back_addr;
         bank_b_we    = back_we;
         bank_b_wdata = back_wdata;
      end
   end

   // Select by the bank that was front when the address was sampled, so no word is torn at a swap
   assign {rd_data_top, rd_data_btm} = front_sel_d ? bank_b_rdata : bank_a_rdata;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: directed vector table, hand sequences for reset/clear corners, and
// randomized traffic against a bank-content reference model (honours FB_SWAP_CLEAR_EN).
`timescale 1ns/1ps
module tb_fb_swap_ctrl;
   localparam int AW = 10;
   localparam int PW = 12;
   localparam int DW = 2*PW;
   localparam int N  = 1 << AW;
`ifdef FB_SWAP_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_data_top, rd_data_btm;
   logic          frame_end, wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          swap_req, swap_done;
   logic [PW-1:0] clear_color;
   logic          clr_busy, front_sel;
   logic [AW-1:0] bank_a_addr, bank_b_addr;
   logic          bank_a_we, bank_b_we;
   logic [DW-1:0] bank_a_wdata, bank_b_wdata, bank_a_rdata, bank_b_rdata;

   fb_swap_ctrl #(.ADDR_W(AW), .PIX_W(PW)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data_top(rd_data_top), .rd_data_btm(rd_data_btm),
      .frame_end(frame_end), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .swap_req(swap_req), .swap_done(swap_done), .clear_color(clear_color),
      .clr_busy(clr_busy), .front_sel(front_sel),
      .bank_a_addr(bank_a_addr), .bank_a_we(bank_a_we), .bank_a_wdata(bank_a_wdata), .bank_a_rdata(bank_a_rdata),
      .bank_b_addr(bank_b_addr), .bank_b_we(bank_b_we), .bank_b_wdata(bank_b_wdata), .bank_b_rdata(bank_b_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAMs, 1-cycle latency; contents seeded by mem_init
   logic          mem_init;
   logic [DW-1:0] mem_a [N];
   logic [DW-1:0] mem_b [N];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < N; i++) begin
            mem_a[i] <= {12'hA00, 12'(i)};
            mem_b[i] <= {12'hB00, 12'(i)};
         end
      end else begin
         if (bank_a_we) mem_a[bank_a_addr] <= bank_a_wdata;
         if (bank_b_we) mem_b[bank_b_addr] <= bank_b_wdata;
         bank_a_rdata <= mem_a[bank_a_addr];
         bank_b_rdata <= mem_b[bank_b_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected contents of both banks, which one is front, and pending/clear work
   logic [DW-1:0] ref_mem [2][N];
   bit            ref_front;
   bit            pending;
   int            clear_left;
   bit            m_ready;
   bit            m_done;

   task automatic mstep(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit sr, input bit fe, input logic [AW-1:0] ra, input logic [PW-1:0] cc);
      logic          f_we, b_we, e_we;
      logic [AW-1:0] f_addr, b_addr, e_addr;
      logic [DW-1:0] b_wd, e_wd, exp_rd;
      bit            idle_pre, back;
      wr_valid = wv; wr_addr = wa; wr_data = wd; swap_req = sr; frame_end = fe;
      rd_addr = ra; clear_color = cc;
      #1;
      if (ref_front == 1'b0) begin
         f_we = bank_a_we; f_addr = bank_a_addr; b_we = bank_b_we; b_addr = bank_b_addr; b_wd = bank_b_wdata;
      end else begin
         f_we = bank_b_we; f_addr = bank_b_addr; b_we = bank_a_we; b_addr = bank_a_addr; b_wd = bank_a_wdata;
      end
      e_we   = (clear_left > 0) || (m_ready && wv);
      e_addr = (clear_left > 0) ? AW'(N - clear_left) : wa;
      e_wd   = (clear_left > 0) ? {cc, cc} : wd;
      chk("front_we", 64'(f_we), 64'd0);
      chk("front_addr", 64'(f_addr), 64'(ra));
      chk("back_we", 64'(b_we), 64'(e_we));
      if (e_we) begin
         chk("back_addr", 64'(b_addr), 64'(e_addr));
         chk("back_wdata", 64'(b_wd), 64'(e_wd));
      end
      exp_rd   = ref_mem[ref_front][ra];
      back     = ~ref_front;
      idle_pre = !pending && clear_left == 0;
      if (clear_left > 0) begin
         ref_mem[back][N - clear_left] = {cc, cc};
         clear_left--;
      end else if (m_ready && wv) begin
         ref_mem[back][wa] = wd;
      end
      m_done = 1'b0;
      if (pending && fe) begin
         ref_front  = back;
         pending    = 1'b0;
         m_done     = 1'b1;
         clear_left = CLR ? N : 0;
      end else if (idle_pre && sr) begin
         pending = 1'b1;
      end
      m_ready = !pending && clear_left == 0;
      @(posedge clk); #1;
      chk("wr_ready", 64'(wr_ready), 64'(m_ready));
      chk("swap_done", 64'(swap_done), 64'(m_done));
      chk("front_sel", 64'(front_sel), 64'(ref_front));
      chk("clr_busy", 64'(clr_busy), 64'(clear_left > 0));
      chk("rd_data", 64'({rd_data_top, rd_data_btm}), 64'(exp_rd));
   endtask

   task automatic idle_step(input logic [AW-1:0] ra);
      mstep(1'b0, '0, '0, 1'b0, 1'b0, ra, 12'h00F);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      wr_valid = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
      #1;
      chk("rst_front_sel", 64'(front_sel), 64'd0);
      chk("rst_swap_done", 64'(swap_done), 64'd0);
      chk("rst_clr_busy", 64'(clr_busy), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_we", 64'({bank_a_we, bank_b_we}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         ref_mem[0][i] = mem_a[i];
         ref_mem[1][i] = mem_b[i];
      end
      ref_front = 1'b0; pending = 1'b0; clear_left = 0; m_ready = 1'b0; m_done = 1'b0;
   endtask

   typedef struct {
      bit            wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      bit            sr, fe;
      logic [AW-1:0] ra;
      bit            e_ready, e_done, e_fs, e_busy;
      logic [DW-1:0] e_rd;
   } vec_t;

   vec_t tv [8];

   initial begin
      int busy_cycles, bad;

      tv[0] = '{1'b0, 10'd0, 24'h000000, 1'b0, 1'b0, 10'd5, 1'b1,  1'b0, 1'b0, 1'b0, 24'hA00005};
      tv[1] = '{1'b1, 10'd5, 24'h0F00F0, 1'b0, 1'b0, 10'd5, 1'b1,  1'b0, 1'b0, 1'b0, 24'hA00005};
      tv[2] = '{1'b0, 10'd0, 24'h000000, 1'b1, 1'b1, 10'd5, 1'b0,  1'b0, 1'b0, 1'b0, 24'hA00005};
      tv[3] = '{1'b1, 10'd7, 24'h123456, 1'b0, 1'b0, 10'd5, 1'b0,  1'b0, 1'b0, 1'b0, 24'hA00005};
      tv[4] = '{1'b1, 10'd7, 24'h123456, 1'b0, 1'b1, 10'd5, !CLR,  1'b1, 1'b1, CLR,  24'hA00005};
      tv[5] = '{1'b0, 10'd0, 24'h000000, 1'b0, 1'b0, 10'd5, !CLR,  1'b0, 1'b1, CLR,  24'h0F00F0};
      tv[6] = '{1'b0, 10'd0, 24'h000000, 1'b0, 1'b0, 10'd7, !CLR,  1'b0, 1'b1, CLR,  24'hB00007};
      tv[7] = '{1'b0, 10'd0, 24'h000000, 1'b0, 1'b1, 10'd7, !CLR,  1'b0, 1'b1, CLR,  24'hB00007};

      rst = 1'b0; mem_init = 1'b1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0; frame_end = 1'b0;
      rd_addr = '0; clear_color = 12'h00F;
      @(posedge clk); #1;
      mem_init = 1'b0;

      // Write, coincident swap_req/frame_end, blocked write while pending, swap, read-back
      do_reset();
      for (int i = 0; i < 8; i++) begin
         wr_valid = tv[i].wv; wr_addr = tv[i].wa; wr_data = tv[i].wd;
         swap_req = tv[i].sr; frame_end = tv[i].fe; rd_addr = tv[i].ra;
         @(posedge clk); #1;
         chk("tbl_wr_ready", 64'(wr_ready), 64'(tv[i].e_ready));
         chk("tbl_swap_done", 64'(swap_done), 64'(tv[i].e_done));
         chk("tbl_front_sel", 64'(front_sel), 64'(tv[i].e_fs));
         chk("tbl_clr_busy", 64'(clr_busy), 64'(tv[i].e_busy));
         chk("tbl_rd_data", 64'({rd_data_top, rd_data_btm}), 64'(tv[i].e_rd));
      end

      // Reset while a swap is pending: swap aborted, frame_end after release ignored
      do_reset();
      idle_step(10'd1);
      mstep(1'b0, '0, '0, 1'b1, 1'b0, 10'd2, 12'h00F);
      mstep(1'b0, '0, '0, 1'b0, 1'b1, 10'd3, 12'h00F);
      for (int k = 0; k < 1100 && clear_left > 0; k++) idle_step(AW'(k));
      mstep(1'b0, '0, '0, 1'b1, 1'b0, 10'd4, 12'h00F);
      idle_step(10'd5);
      do_reset();
      mstep(1'b1, 10'd9, 24'h111111, 1'b0, 1'b1, 10'd9, 12'h00F);
      mstep(1'b0, '0, '0, 1'b0, 1'b1, 10'd9, 12'h00F);

`ifdef FB_SWAP_CLEAR_EN
      // Full clear: length, wr_ready low throughout, every cleared word
      do_reset();
      idle_step(10'd0);
      mstep(1'b0, '0, '0, 1'b1, 1'b0, 10'd0, 12'h00F);
      mstep(1'b0, '0, '0, 1'b0, 1'b1, 10'd0, 12'h00F);
      busy_cycles = 0;
      for (int k = 0; k < 2000 && clr_busy; k++) begin
         busy_cycles++;
         mstep(1'b1, AW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, AW'($urandom), 12'h00F);
      end
      chk("clr_len", 64'(busy_cycles), 64'd1024);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem_a[i] !== 24'h00F00F) bad++;
      chk("clr_words", 64'(bad), 64'd0);

      // Reset at clear count 300
      do_reset();
      idle_step(10'd0);
      mstep(1'b0, '0, '0, 1'b1, 1'b0, 10'd0, 12'h00F);
      mstep(1'b0, '0, '0, 1'b0, 1'b1, 10'd0, 12'h00F);
      for (int k = 0; k < 300; k++) idle_step(AW'(k));
      do_reset();
      mstep(1'b0, '0, '0, 1'b0, 1'b1, 10'd0, 12'h0A5);
      idle_step(10'd1);
`endif

      // Incrementing read sweep across a swap
      do_reset();
      for (int c = 0; c < 300; c++)
         mstep($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), c == 10, c == 40 || c == 150,
               AW'(c), PW'($urandom));

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++)
         mstep($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), $urandom_range(0, 9) == 0,
               $urandom_range(0, 19) == 0, AW'($urandom), PW'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the pixel-pair address width (1024 top/bottom pixel pairs).
REQ-002 SHALL have parameter PIX_W, default 12, giving the RGB444 pixel width; bank words are 2*PIX_W bits as {top,btm}.
REQ-003 SHALL have port clk, in, 1, the sole clock.
REQ-004 SHALL have port rst, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port rd_addr, in, ADDR_W, the display controller read address.
REQ-006 SHALL have ports rd_data_top and rd_data_btm, out, PIX_W each, the front-bank pixel pair.
REQ-007 SHALL have port frame_end, in, 1, a one-cycle pulse from the display controller when a frame scan completes.
REQ-008 SHALL have ports wr_valid (in, 1), wr_ready (out, 1), wr_addr (in, ADDR_W) and wr_data (in, 2*PIX_W) for the renderer write channel.
REQ-009 SHALL have ports swap_req (in, 1, pulse) and swap_done (out, 1, pulse) for the renderer.
REQ-010 SHALL have ports clear_color (in, PIX_W), clr_busy (out, 1) and front_sel (out, 1; 0 = bank A front).
REQ-011 SHALL have ports bank_a_addr (out, ADDR_W), bank_a_we (out, 1), bank_a_wdata (out, 2*PIX_W) and bank_a_rdata (in, 2*PIX_W), plus an identical bank_b_* set; the banks are synchronous-read RAMs with 1-cycle latency.

Function
REQ-012 SHALL implement states IDLE, SWAP_PEND and CLEAR.
REQ-013 SHALL drive the front bank address from rd_addr every cycle with we=0.
REQ-014 SHALL mux rd_data from the front bank rdata using a 1-cycle-delayed copy of front_sel, giving 1-cycle rd_addr->rd_data latency with no torn word at a swap.
REQ-015 SHALL assert wr_ready only in IDLE; on wr_valid&wr_ready it SHALL drive the back bank with addr=wr_addr, wdata=wr_data and we=1 in that same cycle.
REQ-016 SHALL drive the back bank we=0 when no write is occurring.
REQ-017 SHALL, on swap_req in IDLE, move to SWAP_PEND; a write handshaking in the same cycle SHALL still be committed.
REQ-018 SHALL ignore swap_req outside IDLE, and SHALL ignore frame_end in IDLE and CLEAR.
REQ-019 SHALL wait for the next frame_end in SWAP_PEND; a frame_end coincident with swap_req in IDLE SHALL NOT complete the swap.
REQ-020 SHALL, on frame_end in SWAP_PEND, toggle front_sel at the next edge and pulse swap_done high for exactly that one cycle.
REQ-021 SHALL leave SWAP_PEND for CLEAR when clearing is compiled in (REQ-026), else for IDLE.
REQ-022 SHALL, in CLEAR, write {clear_color,clear_color} to the new back bank at addresses 0..2^ADDR_W-1, one per cycle, with clr_busy=1 and wr_ready=0, then enter IDLE after the write at the last address; CLEAR lasts 1024 cycles by default.
REQ-023 SHALL sample clear_color on each CLEAR cycle.

Reset
REQ-024 SHALL, while rst=0, force state=IDLE, front_sel=0, the delayed front_sel=0, the clear counter=0, swap_done=0, clr_busy=0, wr_ready=0 and both bank we=0; bank contents are not reset.
REQ-025 SHALL, when reset is asserted mid-SWAP_PEND or mid-CLEAR, abort the operation (no swap_done) and raise wr_ready on the first edge after release.

Configuration
REQ-026 SHALL compile the CLEAR state, the clear counter and the clr_busy drive only when FB_SWAP_CLEAR_EN is defined; without it, clr_busy SHALL be tied 0, clear_color SHALL be unused, and swaps SHALL return directly to IDLE.

Verification
REQ-027 SHALL cover: write 0x0F00F0 at addr 5, swap, frame_end -> swap_done 1 cycle later, front_sel=1, then rd_addr=5 gives top=0x0F0, btm=0x0F0 one cycle later.
REQ-028 SHALL cover: swap_req and frame_end in the same cycle -> no swap; the swap completes on the following frame_end.
REQ-029 SHALL cover: FB_SWAP_CLEAR_EN defined, clear_color=0x00F -> clr_busy high for exactly 1024 cycles, with back bank words 0..1023 = 0x00F00F and wr_ready low throughout.
REQ-030 SHALL cover: wr_valid held during SWAP_PEND -> wr_ready=0 and no bank write until the return to IDLE.
REQ-031 SHALL cover: rst pulsed low at clear count 300 -> front_sel=0, clr_busy=0 and wr_ready=1 on the first edge after release.
REQ-032 SHALL cover: an incrementing rd_addr sweep across a swap -> every rd_data word comes from a single bank, with the bank change aligned one cycle after the front_sel toggle.
